// File: rtl/alu_pkg.sv
//==============================================================================
// Module   : alu_pkg
// Brief    : Shared opcode, state and flag types for the sequential ALU.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SHL = 3'b101,
        ALU_SHR = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
//==============================================================================
// Module   : alu_mul_iter
// Brief    : Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               running;

    // Upper half accumulates, lower half holds the unconsumed multiplier bits.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                     input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] part;
        part = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {part, p[WIDTH-1:1]};
    endfunction

    // The load edge performs the first step, so count == WIDTH means all bits consumed.
    assign done    = running && (count == CW'(WIDTH));
    assign product = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc     <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand_q <= mcand;
            acc     <= mul_step({{WIDTH{1'b0}}, mplier}, mcand);
            count   <= CW'(1);
            running <= 1'b1;
        end else if (running) begin
            if (done) begin
                running <= 1'b0;
            end else begin
                acc   <= mul_step(acc, mcand_q);
                count <= count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_uadd.sv
//==============================================================================
// Module   : alu_uadd
// Brief    : Unsigned generate/propagate lookahead adder with carry in/out.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_uadd #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] sum,
    output logic            cout
);

    logic [SIZE-1:0] gen;
    logic [SIZE-1:0] prop;
    logic [SIZE:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < SIZE; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum  = prop ^ carry[SIZE-1:0];
    assign cout = carry[SIZE];

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
//==============================================================================
// Module   : alu_seq
// Brief    : Registered valid/ready ALU; iterative MUL when ALU_MUL_EN is defined,
//            otherwise opcode 111 completes in one cycle flagged illegal.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_func,
    input  logic [WIDTH-1:0] i_s1,
    input  logic [WIDTH-1:0] i_s2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_negative,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_illegal
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state;
    alu_state_e       state_nxt;
    alu_op_e          op;
    logic             accept;
    logic             start_mul;
    logic             mul_done;
    logic             add_cin;
    logic             add_cout;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   shl_wide;
    logic [WIDTH:0]   shr_wide;
    logic [WIDTH-1:0] alu_res;
    alu_flags_t       alu_flags;
    logic             alu_ill;
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
    logic             illegal;

    assign op     = alu_op_e'(i_func);
    assign accept = i_valid && (state == ST_IDLE);

    assign add_cin = (op == ALU_SUB);
    assign add_b   = add_cin ? ~i_s2 : i_s2;

    alu_uadd #(.SIZE(WIDTH)) u_add (
        .a    (i_s1),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // One guard bit on the outgoing side captures the last bit shifted out.
    assign amt      = i_s2[SHW-1:0];
    assign shl_wide = {1'b0, i_s1} << amt;
    assign shr_wide = {i_s1, 1'b0} >> amt;

    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        alu_ill   = 1'b0;
        start_mul = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                alu_res            = add_sum;
                alu_flags.carry    = add_cin ? ~add_cout : add_cout;
                alu_flags.overflow = (i_s1[WIDTH-1] == add_b[WIDTH-1]) &&
                                     (add_sum[WIDTH-1] != i_s1[WIDTH-1]);
            end
            ALU_AND: alu_res = i_s1 & i_s2;
            ALU_OR:  alu_res = i_s1 | i_s2;
            ALU_XOR: alu_res = i_s1 ^ i_s2;
            ALU_SHL: begin
                alu_res         = shl_wide[WIDTH-1:0];
                alu_flags.carry = shl_wide[WIDTH];
            end
            ALU_SHR: begin
                alu_res         = shr_wide[WIDTH:1];
                alu_flags.carry = shr_wide[0];
            end
            ALU_MUL: begin
`ifdef ALU_MUL_EN
                start_mul = 1'b1;
`else
                alu_ill   = 1'b1;
`endif
            end
            default: alu_res = '0;
        endcase
        alu_flags.zero     = (alu_res == '0);
        alu_flags.negative = alu_res[WIDTH-1];
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_prod;
    alu_flags_t         mul_flags;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (accept && start_mul),
        .mcand   (i_s1),
        .mplier  (i_s2),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        mul_flags          = '0;
        mul_flags.zero     = (mul_prod[WIDTH-1:0] == '0);
        mul_flags.negative = mul_prod[WIDTH-1];
        mul_flags.carry    = |mul_prod[2*WIDTH-1:WIDTH];
        mul_flags.overflow = |mul_prod[2*WIDTH-1:WIDTH];
    end
`else
    assign mul_done = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)   state_nxt = start_mul ? ST_BUSY : ST_DONE;
            ST_BUSY: if (mul_done) state_nxt = ST_DONE;
            ST_DONE: if (i_ready)  state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            result  <= '0;
            flags   <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && !start_mul) begin
                result  <= alu_res;
                flags   <= alu_flags;
                illegal <= alu_ill;
            end
`ifdef ALU_MUL_EN
            else if (state == ST_BUSY && mul_done) begin
                result  <= mul_prod[WIDTH-1:0];
                flags   <= mul_flags;
                illegal <= 1'b0;
            end
`endif
        end
    end

    assign o_ready    = (state == ST_IDLE);
    assign o_valid    = (state == ST_DONE);
    assign o_result   = result;
    assign o_zero     = flags.zero;
    assign o_negative = flags.negative;
    assign o_carry    = flags.carry;
    assign o_overflow = flags.overflow;
    assign o_illegal  = illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//==============================================================================
// Module   : tb_alu_seq
// Brief    : Self-checking bench for alu_seq: vector table, random ops against an
//            arithmetic reference model, and backpressure/reset sequences.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // res, zero, negative, carry, overflow, illegal
    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
        logic         ill;
    } out_t;

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        out_t         exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_in = 1'b1;
    logic [2:0]   func = 3'd0;
    logic [W-1:0] s1 = '0;
    logic [W-1:0] s2 = '0;
    logic         o_ready, o_valid, o_zero, o_negative, o_carry, o_overflow, o_illegal;
    logic [W-1:0] o_result;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid_in),
        .o_ready    (o_ready),
        .i_func     (func),
        .i_s1       (s1),
        .i_s2       (s2),
        .o_valid    (o_valid),
        .i_ready    (ready_in),
        .o_result   (o_result),
        .o_zero     (o_zero),
        .o_negative (o_negative),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_illegal  (o_illegal)
    );

    function automatic out_t sample();
        return {o_result, o_zero, o_negative, o_carry, o_overflow, o_illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic out_t model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        out_t o;
        int   ua, ub, sa, sb, amt, full, tmp;
        o   = '0;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        amt = ub % W;
        case (f)
            3'd0: begin
                full = ua + ub;  o.res = full[W-1:0]; o.c = (full > 255);
                full = sa + sb;  o.v = (full > 127) || (full < -128);
            end
            3'd1: begin
                full = ua - ub;  o.res = full[W-1:0]; o.c = (ua < ub);
                full = sa - sb;  o.v = (full > 127) || (full < -128);
            end
            3'd2: o.res = a & b;
            3'd3: o.res = a | b;
            3'd4: o.res = a ^ b;
            3'd5: begin
                full = ua * (1 << amt); o.res = full[W-1:0];
                tmp  = (amt == 0) ? 0 : (ua / (1 << (W - amt)));
                o.c  = tmp[0];
            end
            3'd6: begin
                full = ua / (1 << amt); o.res = full[W-1:0];
                tmp  = (amt == 0) ? 0 : (ua / (1 << (amt - 1)));
                o.c  = tmp[0];
            end
            default: begin
                if (MUL_EN) begin
                    full  = ua * ub;
                    o.res = full[W-1:0];
                    o.c   = (full > 255);
                    o.v   = (full > 255);
                end else begin
                    o.ill = 1'b1;
                end
            end
        endcase
        o.z = (o.res == 0);
        o.n = o.res[W-1];
        return o;
    endfunction

    function automatic int exp_lat(input logic [2:0] f);
        return (f == 3'd7 && MUL_EN) ? W + 1 : 1;
    endfunction

    // Issue one op, count cycles until o_valid (bounded), sample, then let it drain.
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output out_t got, output int lat);
        @(negedge clk);
        func = f; s1 = a; s2 = b; valid_in = 1'b1; ready_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got = sample();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t         vt[14];
        out_t         got;
        int           lat;
        logic [2:0]   rf;
        logic [W-1:0] ra, rb;
        int           pulses;

        vt[0]  = '{3'd0, 8'hF0, 8'h20, {8'h10, 5'b00100}};
        vt[1]  = '{3'd1, 8'h80, 8'h01, {8'h7F, 5'b00010}};
        vt[2]  = '{3'd1, 8'h05, 8'h05, {8'h00, 5'b10000}};
        vt[3]  = '{3'd5, 8'h81, 8'h01, {8'h02, 5'b00100}};
        vt[4]  = '{3'd6, 8'h01, 8'h00, {8'h01, 5'b00000}};
        vt[5]  = '{3'd2, 8'hF0, 8'h3C, {8'h30, 5'b00000}};
        vt[6]  = '{3'd3, 8'h0F, 8'hF0, {8'hFF, 5'b01000}};
        vt[7]  = '{3'd4, 8'hAA, 8'hAA, {8'h00, 5'b10000}};
        vt[8]  = '{3'd0, 8'h7F, 8'h01, {8'h80, 5'b01010}};
        vt[9]  = '{3'd6, 8'h81, 8'h09, {8'h40, 5'b00100}};
        vt[10] = '{3'd1, 8'h00, 8'h01, {8'hFF, 5'b01100}};
        vt[11] = '{3'd5, 8'h01, 8'h07, {8'h80, 5'b01000}};
`ifdef ALU_MUL_EN
        vt[12] = '{3'd7, 8'h0C, 8'h0B, {8'h84, 5'b01000}};
        vt[13] = '{3'd7, 8'h10, 8'h10, {8'h00, 5'b10110}};
`else
        vt[12] = '{3'd7, 8'h0C, 8'h0B, {8'h00, 5'b10001}};
        vt[13] = '{3'd7, 8'h10, 8'h10, {8'h00, 5'b10001}};
`endif

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hs", 32'({o_valid, o_ready}), 32'(2'b01));
        check("reset_out", 32'(sample()), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].f, vt[i].a, vt[i].b, got, lat);
            check($sformatf("vec%0d_out", i), 32'(got), 32'(vt[i].exp));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat(vt[i].f)));
        end

        // MUL handshake timing: o_ready low until the result, o_valid only at the end
        @(negedge clk);
        func = 3'd7; s1 = 8'h0C; s2 = 8'h0B; valid_in = 1'b1; ready_in = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        for (int k = 1; k <= exp_lat(3'd7); k++) begin
            check($sformatf("mul_cycle%0d", k), 32'({o_valid, o_ready}),
                  32'({(k == exp_lat(3'd7)), 1'b0}));
            if (k < exp_lat(3'd7)) begin
                @(posedge clk); #1;
            end
        end
        check("mul_seq_out", 32'(sample()), 32'(model(3'd7, 8'h0C, 8'h0B)));
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk); #1;

        // Backpressure: result held, new requests ignored
        @(negedge clk);
        func = 3'd0; s1 = 8'h01; s2 = 8'h01; valid_in = 1'b1; ready_in = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("bp_valid_rise", 32'({o_valid, o_ready, o_result}), 32'({2'b10, 8'h02}));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid_in = 1'b1; func = 3'd0; s1 = 8'hFF; s2 = 8'hFF;
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", k), 32'({o_valid, o_ready, o_result}), 32'({2'b10, 8'h02}));
        end
        @(negedge clk);
        valid_in = 1'b0; ready_in = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'({o_valid, o_ready}), 32'(2'b01));

        // Reset during a MUL discards it with no o_valid pulse
        @(negedge clk);
        func = 3'd7; s1 = 8'h0C; s2 = 8'h0B; valid_in = 1'b1; ready_in = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_hs", 32'({o_valid, o_ready}), 32'(2'b01));
        check("midrst_out", 32'(sample()), 32'(0));
        @(negedge clk);
        rst_n = 1'b1; ready_in = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (o_valid) pulses++;
        end
        check("midrst_no_pulse", 32'(pulses), 32'(0));
        run_op(3'd0, 8'h33, 8'h44, got, lat);
        check("post_rst_add", 32'(got), 32'({8'h77, 5'b00000}));
        check("post_rst_lat", 32'(lat), 32'(1));

        // Random ops against the reference model
        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(rf, ra, rb, got, lat);
            check($sformatf("rnd%0d_f%0d_%02h_%02h", i, rf, ra, rb), 32'(got), 32'(model(rf, ra, rb)));
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat(rf)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
